// File: rtl/aes_gf_pkg.sv
// GF(2^4) arithmetic for the composite field GF((2^4)^2) used by the AES S-box datapath.
// Base field reduction polynomial is x^4+x+1; the outer polynomial is y^2+y+LAMBDA.
package aes_gf_pkg;

  localparam int NB_DATA = 8;
  localparam logic [3:0] LAMBDA = 4'hC;

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ ({3'b000, a} << i);
    end
    for (int i = 6; i >= 4; i--) begin
      if (p[i]) p = p ^ (7'b0010011 << (i - 4));
    end
    return p[3:0];
  endfunction

  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    return gf4_mul(a, a);
  endfunction

  function automatic logic [3:0] gf4_mul_lambda(input logic [3:0] a);
    return gf4_mul(a, LAMBDA);
  endfunction

  // a^-1 = a^14 = a^2 * a^4 * a^8, which also maps 0 to 0
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_sq(a);
    a4 = gf4_sq(a2);
    a8 = gf4_sq(a4);
    return gf4_mul(gf4_mul(a2, a4), a8);
  endfunction

endpackage

// File: rtl/gf2p4_multiplier.sv
// Combinational 4x4 -> 4 bit multiplier in GF(2^4) mod x^4+x+1.
module gf2p4_multiplier
  import aes_gf_pkg::gf4_mul;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p
);

  assign p = gf4_mul(a, b);

endmodule

// File: rtl/state_composite_inversion_pipe.sv
// Three-stage pipelined GF((2^4)^2) inversion over every byte lane of an AES state,
// with a valid/ready handshake and one shared valid chain for all lanes.
module state_composite_inversion_pipe
  import aes_gf_pkg::gf4_sq;
  import aes_gf_pkg::gf4_mul_lambda;
  import aes_gf_pkg::gf4_inv;
#(
  parameter int NB_BYTES = 16,
  parameter int NB_DATA  = 8
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic [NB_BYTES*NB_DATA-1:0] i_delta,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic [NB_BYTES*NB_DATA-1:0] o_inv,
  output logic                        o_valid,
  input  logic                        i_ready
);

  logic v1, v2, v3;
  logic ld1, ld2, ld3;

  // A stage loads when it is empty or its content moves on, so bubbles collapse under stall
  assign ld3     = !v3 || i_ready;
  assign ld2     = !v2 || ld3;
  assign ld1     = !v1 || ld2;
  assign o_ready = ld1;
  assign o_valid = v3;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (ld1) v1 <= i_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
    end
  end

  for (genvar k = 0; k < NB_BYTES; k++) begin : g_lane
    logic [3:0] g1_in, g0_in, g1g0, d_next;
    logic [3:0] s1_d, s1_g1, s1_g0;
    logic [3:0] s2_di, s2_g1, s2_g0, s2_sum;
    logic [3:0] hi_next, lo_next;
    logic [7:0] s3_inv;

    assign g1_in = i_delta[k*NB_DATA+4 +: 4];
    assign g0_in = i_delta[k*NB_DATA +: 4];

    gf2p4_multiplier u_mul_g1g0 (.a(g1_in), .b(g0_in), .p(g1g0));

    assign d_next = gf4_mul_lambda(gf4_sq(g1_in)) ^ g1g0 ^ gf4_sq(g0_in);
    assign s2_sum = s2_g1 ^ s2_g0;

    gf2p4_multiplier u_mul_hi (.a(s2_g1),  .b(s2_di), .p(hi_next));
    gf2p4_multiplier u_mul_lo (.a(s2_sum), .b(s2_di), .p(lo_next));

    // Data registers only capture when a valid item actually enters the stage
    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        s1_d   <= '0;
        s1_g1  <= '0;
        s1_g0  <= '0;
        s2_di  <= '0;
        s2_g1  <= '0;
        s2_g0  <= '0;
        s3_inv <= '0;
      end else begin
        if (ld1 && i_valid) begin
          s1_d  <= d_next;
          s1_g1 <= g1_in;
          s1_g0 <= g0_in;
        end
        if (ld2 && v1) begin
          s2_di <= gf4_inv(s1_d);
          s2_g1 <= s1_g1;
          s2_g0 <= s1_g0;
        end
        if (ld3 && v2) begin
          s3_inv <= {hi_next, lo_next};
        end
      end
    end

    assign o_inv[k*NB_DATA +: NB_DATA] = s3_inv;
  end

endmodule

// File: tb/tb_state_composite_inversion_pipe.sv
// Directed and scoreboarded bench for the composite-field inversion pipeline.
module tb_state_composite_inversion_pipe;

  localparam int NB_BYTES = 16;
  localparam int W = NB_BYTES * 8;

  logic         i_clock = 1'b0;
  logic         i_reset_n;
  logic [W-1:0] i_delta;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] o_inv;
  logic         o_valid;
  logic         i_ready;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] golden [256];

  always #5 i_clock = ~i_clock;

  state_composite_inversion_pipe #(.NB_BYTES(NB_BYTES), .NB_DATA(8)) dut (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_delta  (i_delta),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_inv    (o_inv),
    .o_valid  (o_valid),
    .i_ready  (i_ready)
  );

  // Shift-and-add GF(2^4) product, xtime by x^4 = x + 1
  function automatic logic [3:0] m4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic [3:0] t;
    r = 4'h0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  // (a1 y + a0)(b1 y + b0) with y^2 = y + lambda
  function automatic logic [7:0] cmul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = m4(a[7:4], b[7:4]);
    return {hh ^ m4(a[7:4], b[3:0]) ^ m4(a[3:0], b[7:4]), m4(a[3:0], b[3:0]) ^ m4(4'hC, hh)};
  endfunction

  function automatic logic [W-1:0] expect_state(input logic [W-1:0] s);
    logic [W-1:0] r;
    for (int k = 0; k < NB_BYTES; k++) r[8*k +: 8] = golden[s[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_valid   = 1'b1;
    i_ready   = 1'b1;
    i_delta   = {NB_BYTES{8'h5A}};
    repeat (3) tick();
    @(negedge i_clock);
    total_cnt++;
    if (o_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", o_valid);
    else pass_cnt++;
    total_cnt++;
    if (o_inv !== '0) $display("[TB] FAIL reset_inv got %h want 0", o_inv);
    else pass_cnt++;
    tick();
    i_valid   = 1'b0;
    i_reset_n = 1'b1;
    @(negedge i_clock);
    total_cnt++;
    if (o_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", o_ready);
    else pass_cnt++;
    repeat (4) tick();
    @(negedge i_clock);
    total_cnt++;
    if (o_valid !== 1'b0) $display("[TB] FAIL reset_no_transfer got %b want 0", o_valid);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_identities();
    logic [W-1:0] vin [3];
    logic [W-1:0] vexp [3];
    logic [W-1:0] got;
    int lat;
    vin[0]  = {NB_BYTES{8'h00}};
    vexp[0] = {NB_BYTES{8'h00}};
    vin[1]  = {NB_BYTES{8'h01}};
    vexp[1] = {NB_BYTES{8'h01}};
    vin[2]  = {{11{8'h01}}, 8'h11, 8'h02, 8'h10, 8'h01, 8'h00};
    vexp[2] = {{11{8'h01}}, 8'hA0, 8'h09, 8'hAA, 8'h01, 8'h00};
    i_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      i_delta = vin[v];
      i_valid = 1'b1;
      @(negedge i_clock);
      total_cnt++;
      if (o_ready !== 1'b1) $display("[TB] FAIL ident_ready[%0d] got %b want 1", v, o_ready);
      else pass_cnt++;
      tick();
      i_valid = 1'b0;
      lat = 0;
      got = '0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge i_clock);
        if (o_valid && lat == 0) begin
          lat = c;
          got = o_inv;
        end
        tick();
      end
      total_cnt++;
      if (lat != 3) $display("[TB] FAIL ident_latency[%0d] got %0d want 3", v, lat);
      else pass_cnt++;
      total_cnt++;
      if (got !== vexp[v]) $display("[TB] FAIL ident_value[%0d] got %h want %h", v, got, vexp[v]);
      else pass_cnt++;
    end
  endtask

  task automatic test_exhaustive();
    logic [W-1:0] src [$];
    logic [W-1:0] inq [$];
    logic [W-1:0] s, ein;
    logic         prod_ok;
    int sent = 0;
    int got = 0;
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 16; k++) s[8*k +: 8] = 8'(16 * j + k);
      src.push_back(s);
    end
    i_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && got < 16; cyc++) begin
      i_valid = (sent < 16);
      i_delta = (sent < 16) ? src[sent] : '0;
      @(negedge i_clock);
      if (i_valid && o_ready) begin
        inq.push_back(src[sent]);
        sent++;
      end
      if (o_valid && i_ready) begin
        total_cnt++;
        if (inq.size() == 0) begin
          $display("[TB] FAIL exh_unexpected got %h want none", o_inv);
        end else begin
          ein = inq.pop_front();
          if (o_inv !== expect_state(ein)) $display("[TB] FAIL exh_table[%0d] got %h want %h", got, o_inv, expect_state(ein));
          else pass_cnt++;
          prod_ok = 1'b1;
          for (int k = 0; k < NB_BYTES; k++) begin
            if (ein[8*k +: 8] == 8'h00) prod_ok &= (o_inv[8*k +: 8] === 8'h00);
            else prod_ok &= (cmul(o_inv[8*k +: 8], ein[8*k +: 8]) === 8'h01);
          end
          total_cnt++;
          if (!prod_ok) $display("[TB] FAIL exh_product[%0d] got %h want inverse of %h", got, o_inv, ein);
          else pass_cnt++;
        end
        got++;
      end
      tick();
    end
    i_valid = 1'b0;
    total_cnt++;
    if (got != 16) $display("[TB] FAIL exh_count got %0d want 16", got);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic [W-1:0] src [$];
    logic [W-1:0] expq [$];
    logic [W-1:0] e;
    int sent = 0;
    int got = 0;
    int gaps = 0;
    int errs = 0;
    for (int i = 0; i < 100; i++) src.push_back(rand_state());
    i_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && got < 100; cyc++) begin
      i_valid = (sent < 100);
      i_delta = (sent < 100) ? src[sent] : '0;
      @(negedge i_clock);
      if (got > 0 && !o_valid) gaps++;
      if (i_valid && o_ready) begin
        expq.push_back(expect_state(src[sent]));
        sent++;
      end
      if (o_valid && i_ready) begin
        if (expq.size() == 0) begin
          errs++;
          $display("[TB] FAIL stream_unexpected got %h want none", o_inv);
        end else begin
          e = expq.pop_front();
          if (o_inv !== e) begin
            errs++;
            $display("[TB] FAIL stream_value[%0d] got %h want %h", got, o_inv, e);
          end
        end
        got++;
      end
      tick();
    end
    i_valid = 1'b0;
    total_cnt++;
    if (errs != 0) $display("[TB] FAIL stream_data got %0d bad want 0", errs);
    else pass_cnt++;
    total_cnt++;
    if (got != 100) $display("[TB] FAIL stream_count got %0d want 100", got);
    else pass_cnt++;
    total_cnt++;
    if (gaps != 0) $display("[TB] FAIL stream_continuous got %0d gaps want 0", gaps);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] src [$];
    logic [W-1:0] expq [$];
    logic [W-1:0] e, prev_inv;
    logic         prev_stall;
    int sent = 0;
    int got = 0;
    prev_stall = 1'b0;
    prev_inv   = '0;
    for (int i = 0; i < 20; i++) src.push_back(rand_state());
    for (int cyc = 0; cyc < 100 && got < 20; cyc++) begin
      i_valid = (sent < 20);
      i_delta = (sent < 20) ? src[sent] : '0;
      i_ready = !(cyc >= 2 && cyc < 12);
      @(negedge i_clock);
      if (!i_ready) begin
        total_cnt++;
        if (o_ready !== ((sent - got) < 3)) $display("[TB] FAIL bp_ready[%0d] got %b want %b", cyc, o_ready, (sent - got) < 3);
        else pass_cnt++;
      end
      if (prev_stall) begin
        total_cnt++;
        if (o_valid !== 1'b1 || o_inv !== prev_inv) $display("[TB] FAIL bp_hold[%0d] got %b/%h want 1/%h", cyc, o_valid, o_inv, prev_inv);
        else pass_cnt++;
      end
      if (cyc == 11) begin
        total_cnt++;
        if (sent - got != 3) $display("[TB] FAIL bp_fill got %0d want 3", sent - got);
        else pass_cnt++;
      end
      prev_stall = o_valid && !i_ready;
      prev_inv   = o_inv;
      if (i_valid && o_ready) begin
        expq.push_back(expect_state(src[sent]));
        sent++;
      end
      if (o_valid && i_ready) begin
        total_cnt++;
        if (expq.size() == 0) begin
          $display("[TB] FAIL bp_unexpected got %h want none", o_inv);
        end else begin
          e = expq.pop_front();
          if (o_inv !== e) $display("[TB] FAIL bp_value[%0d] got %h want %h", got, o_inv, e);
          else pass_cnt++;
        end
        got++;
      end
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    total_cnt++;
    if (got != 20 || expq.size() != 0) $display("[TB] FAIL bp_count got %0d want 20", got);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] expq [$];
    logic [W-1:0] cur, e;
    cur = rand_state();
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc == 120) begin
        #2 i_reset_n = 1'b0;
        #1;
        total_cnt++;
        if (o_valid !== 1'b0 || o_inv !== '0) $display("[TB] FAIL rnd_reset got %b/%h want 0/0", o_valid, o_inv);
        else pass_cnt++;
        expq.delete();
        i_valid = 1'b0;
        tick();
        i_reset_n = 1'b1;
        @(negedge i_clock);
        total_cnt++;
        if (o_ready !== 1'b1) $display("[TB] FAIL rnd_ready_after_reset got %b want 1", o_ready);
        else pass_cnt++;
        tick();
        continue;
      end
      i_valid = ($urandom_range(3) != 0);
      i_delta = cur;
      i_ready = ($urandom_range(2) != 0);
      @(negedge i_clock);
      if (i_valid && o_ready) begin
        expq.push_back(expect_state(cur));
        cur = rand_state();
      end
      if (o_valid && i_ready) begin
        total_cnt++;
        if (expq.size() == 0) begin
          $display("[TB] FAIL rnd_unexpected got %h want none", o_inv);
        end else begin
          e = expq.pop_front();
          if (o_inv !== e) $display("[TB] FAIL rnd_value[%0d] got %h want %h", cyc, o_inv, e);
          else pass_cnt++;
        end
      end
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge i_clock);
      if (o_valid) begin
        total_cnt++;
        if (expq.size() == 0) begin
          $display("[TB] FAIL rnd_drain_unexpected got %h want none", o_inv);
        end else begin
          e = expq.pop_front();
          if (o_inv !== e) $display("[TB] FAIL rnd_drain_value got %h want %h", o_inv, e);
          else pass_cnt++;
        end
      end
      tick();
    end
    total_cnt++;
    if (expq.size() != 0) $display("[TB] FAIL rnd_lost got %0d pending want 0", expq.size());
    else pass_cnt++;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    i_delta   = '0;
    golden[0] = 8'h00;
    for (int a = 1; a < 256; a++) begin
      golden[a] = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (cmul(8'(a), 8'(b)) == 8'h01) golden[a] = 8'(b);
      end
    end
    test_reset();
    test_identities();
    test_exhaustive();
    test_streaming();
    test_backpressure();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
